synchronizer_vec_filt: RTL and testbench

- Parametrised successor of the single-bit N-stage synchronizer.
- Brings W independent asynchronous level inputs into the clk domain through an N-flop ASYNC_REG chain per channel.
- Adds a per-channel stability (deglitch) filter and registered rise/fall event pulses.
- Used for front-panel, trigger and status lines that feed QICK control logic, where glitch rejection and edge events are needed, not just a metastability-safe level.

---
 rtl/sync_pkg.sv | 18 +
 rtl/sync_filt_ch.sv | 95 +++++++++
 rtl/synchronizer_vec_filt.sv | 48 ++++
 tb/tb_synchronizer_vec_filt.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared constants, helpers and types for the vector synchronizer/deglitch filter.
// The optional per-channel event counters are enabled with the SYNC_EVT_CNT_EN macro.
package sync_pkg;

    localparam int SYNC_MIN_STAGES = 2;
    localparam int SYNC_FC_MAX_W   = 16;

    function automatic int filt_cnt_w(input int filt);
        return (filt < 1) ? 1 : $clog2(filt + 1);
    endfunction

    // Filter state per channel: held output level and persistence counter.
    typedef struct packed {
        logic                     q;
        logic [SYNC_FC_MAX_W-1:0] fc;
    } filt_state_t;

endpackage

// File: rtl/sync_filt_ch.sv
// One channel: N-flop synchronizer chain, persistence filter, edge pulses and,
// when SYNC_EVT_CNT_EN is defined, a saturating rising-event counter.
module sync_filt_ch
    import sync_pkg::*;
#(
    parameter int   N        = 2,
    parameter int   FILT     = 0,
    parameter logic INIT_BIT = 1'b0,
    parameter int   CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
`ifdef SYNC_EVT_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] evt_cnt,
`endif
    output logic             data_out,
    output logic             rise,
    output logic             fall
);

    localparam logic [SYNC_FC_MAX_W-1:0] FILT_V = SYNC_FC_MAX_W'(FILT);
    localparam logic [SYNC_FC_MAX_W-1:0] FC_ONE = SYNC_FC_MAX_W'(1);

    if (FILT < 0 || filt_cnt_w(FILT) > SYNC_FC_MAX_W) begin : g_bad_filt
        $error("sync_filt_ch: FILT out of range");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sync_filt_ch: CNT_W must be at least 1");
    end

    (* ASYNC_REG = "TRUE" *) logic [N-1:0] sync_reg;
    filt_state_t st_reg;
    logic        rise_reg;
    logic        fall_reg;
    logic        s;
    logic        update;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= {N{INIT_BIT}};
        end else begin
            sync_reg <= {sync_reg[N-2:0], data_in};
        end
    end

    assign s      = sync_reg[N-1];
    assign update = (s != st_reg.q) && (st_reg.fc == FILT_V);

    // The counter restarts whenever s agrees with the output, so any
    // excursion shorter than FILT+1 samples never reaches an update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_reg.q  <= INIT_BIT;
            st_reg.fc <= '0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            rise_reg <= update & s;
            fall_reg <= update & ~s;
            if ((s == st_reg.q) || update) begin
                st_reg.fc <= '0;
            end else begin
                st_reg.fc <= st_reg.fc + FC_ONE;
            end
            if (update) begin
                st_reg.q <= s;
            end
        end
    end

    assign data_out = st_reg.q;
    assign rise     = rise_reg;
    assign fall     = fall_reg;

`ifdef SYNC_EVT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] cnt_reg;

    // Clear takes priority but a coincident rise still counts as the first event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (cnt_clr) begin
            cnt_reg <= (update && s) ? CNT_W'(1) : '0;
        end else if (update && s && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign evt_cnt = cnt_reg;
`endif

endmodule

// File: rtl/synchronizer_vec_filt.sv
// W-channel level synchronizer with deglitch filter and rise/fall pulses.
// Optional per-channel event counters exist only when SYNC_EVT_CNT_EN is defined.
module synchronizer_vec_filt
    import sync_pkg::*;
#(
    parameter int           W     = 1,
    parameter int           N     = 2,
    parameter int           FILT  = 0,
    parameter logic [W-1:0] INIT  = '0,
    parameter int           CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       data_in,
`ifdef SYNC_EVT_CNT_EN
    input  logic               cnt_clr,
    output logic [W*CNT_W-1:0] evt_cnt,
`endif
    output logic [W-1:0]       data_out,
    output logic [W-1:0]       rise,
    output logic [W-1:0]       fall
);

    if (N < SYNC_MIN_STAGES) begin : g_bad_n
        $error("synchronizer_vec_filt: N must be at least SYNC_MIN_STAGES");
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_ch
        sync_filt_ch #(
            .N        (N),
            .FILT     (FILT),
            .INIT_BIT (INIT[gi]),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .data_in  (data_in[gi]),
`ifdef SYNC_EVT_CNT_EN
            .cnt_clr  (cnt_clr),
            .evt_cnt  (evt_cnt[gi*CNT_W +: CNT_W]),
`endif
            .data_out (data_out[gi]),
            .rise     (rise[gi]),
            .fall     (fall[gi])
        );
    end

endmodule

// File: tb/tb_synchronizer_vec_filt.sv
// Randomized and directed bench for synchronizer_vec_filt over four configurations,
// checked against a sample-history reference model.
module tb_synchronizer_vec_filt;

    logic clk = 1'b0;
    logic rst;
    logic cnt_clr;
    always #5 clk = ~clk;

    int         p_w    [4] = '{4, 1, 1, 2};
    int         p_n    [4] = '{2, 3, 2, 2};
    int         p_f    [4] = '{0, 0, 3, 2};
    int         p_cw   [4] = '{8, 8, 2, 2};
    logic [3:0] p_init [4] = '{4'b0101, 4'b0000, 4'b0000, 4'b0010};

    logic [3:0] din [4];
    logic [3:0] d0_in, d0_q, d0_r, d0_f;
    logic [0:0] d1_in, d1_q, d1_r, d1_f;
    logic [0:0] d2_in, d2_q, d2_r, d2_f;
    logic [1:0] d3_in, d3_q, d3_r, d3_f;
    logic [31:0] d0_evt;
    logic [7:0]  d1_evt;
    logic [1:0]  d2_evt;
    logic [3:0]  d3_evt;

    assign d0_in = din[0];
    assign d1_in = din[1][0:0];
    assign d2_in = din[2][0:0];
    assign d3_in = din[3][1:0];

    synchronizer_vec_filt #(.W(4), .N(2), .FILT(0), .INIT(4'b0101), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(d0_in),
`ifdef SYNC_EVT_CNT_EN
        .cnt_clr(cnt_clr), .evt_cnt(d0_evt),
`endif
        .data_out(d0_q), .rise(d0_r), .fall(d0_f));

    synchronizer_vec_filt #(.W(1), .N(3), .FILT(0), .INIT(1'b0), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(d1_in),
`ifdef SYNC_EVT_CNT_EN
        .cnt_clr(cnt_clr), .evt_cnt(d1_evt),
`endif
        .data_out(d1_q), .rise(d1_r), .fall(d1_f));

    synchronizer_vec_filt #(.W(1), .N(2), .FILT(3), .INIT(1'b0), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(d2_in),
`ifdef SYNC_EVT_CNT_EN
        .cnt_clr(cnt_clr), .evt_cnt(d2_evt),
`endif
        .data_out(d2_q), .rise(d2_r), .fall(d2_f));

    synchronizer_vec_filt #(.W(2), .N(2), .FILT(2), .INIT(2'b10), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .data_in(d3_in),
`ifdef SYNC_EVT_CNT_EN
        .cnt_clr(cnt_clr), .evt_cnt(d3_evt),
`endif
        .data_out(d3_q), .rise(d3_r), .fall(d3_f));

    logic [3:0] g_q [4];
    logic [3:0] g_r [4];
    logic [3:0] g_f [4];
    int         g_evt [4][4];

    always_comb begin
        g_q[0] = d0_q;         g_r[0] = d0_r;         g_f[0] = d0_f;
        g_q[1] = {3'b0, d1_q}; g_r[1] = {3'b0, d1_r}; g_f[1] = {3'b0, d1_f};
        g_q[2] = {3'b0, d2_q}; g_r[2] = {3'b0, d2_r}; g_f[2] = {3'b0, d2_f};
        g_q[3] = {2'b0, d3_q}; g_r[3] = {2'b0, d3_r}; g_f[3] = {2'b0, d3_f};
        for (int d = 0; d < 4; d++)
            for (int c = 0; c < 4; c++)
                g_evt[d][c] = 0;
        for (int c = 0; c < 4; c++)
            g_evt[0][c] = 32'(d0_evt[c*8 +: 8]);
        g_evt[1][0] = 32'(d1_evt);
        g_evt[2][0] = 32'(d2_evt);
        g_evt[3][0] = 32'(d3_evt[1:0]);
        g_evt[3][1] = 32'(d3_evt[3:2]);
    end

    // Reference model: raw sample history and history of synced values since reset.
    bit         mh_din [4][4][16];
    int         mn_din [4][4];
    bit         mh_s   [4][4][16];
    int         mn_s   [4][4];
    logic [3:0] m_q    [4];
    logic [3:0] m_rise [4];
    logic [3:0] m_fall [4];
    int         m_evt  [4][4];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_rise [4];
    int n_fall [4];
    int last_rise [4];
    int last_fall [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_q[d]    = p_init[d];
            m_rise[d] = '0;
            m_fall[d] = '0;
            for (int c = 0; c < 4; c++) begin
                mn_din[d][c] = 0;
                mn_s[d][c]   = 0;
                m_evt[d][c]  = 0;
            end
        end
    endtask

    task automatic model_edge();
        bit s;
        bit upd;
        int cmax;
        for (int d = 0; d < 4; d++) begin
            cmax = (1 << p_cw[d]) - 1;
            for (int c = 0; c < p_w[d]; c++) begin
                for (int j = 15; j > 0; j--) mh_din[d][c][j] = mh_din[d][c][j-1];
                mh_din[d][c][0] = din[d][c];
                if (mn_din[d][c] < 16) mn_din[d][c]++;
                s = (mn_din[d][c] > p_n[d]) ? mh_din[d][c][p_n[d]] : p_init[d][c];
                for (int j = 15; j > 0; j--) mh_s[d][c][j] = mh_s[d][c][j-1];
                mh_s[d][c][0] = s;
                if (mn_s[d][c] < 16) mn_s[d][c]++;
                // New level accepted once the last FILT+1 synced samples all disagree with it.
                upd = (mn_s[d][c] >= p_f[d] + 1);
                for (int j = 0; j <= p_f[d]; j++)
                    if (mh_s[d][c][j] == m_q[d][c]) upd = 1'b0;
                m_rise[d][c] = upd & s;
                m_fall[d][c] = upd & ~s;
                if (upd) m_q[d][c] = s;
                if (cnt_clr) m_evt[d][c] = (upd & s) ? 1 : 0;
                else if ((upd & s) && m_evt[d][c] < cmax) m_evt[d][c]++;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 4; d++) begin
            check($sformatf("d%0d_data_out", d), g_q[d], m_q[d]);
            check($sformatf("d%0d_rise", d), g_r[d], m_rise[d]);
            check($sformatf("d%0d_fall", d), g_f[d], m_fall[d]);
`ifdef SYNC_EVT_CNT_EN
            for (int c = 0; c < p_w[d]; c++)
                check($sformatf("d%0d_evt%0d", d, c), g_evt[d][c], m_evt[d][c]);
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        cyc++;
        #1;
        check_all();
        for (int d = 0; d < 4; d++) begin
            if (g_r[d] != 0) begin n_rise[d]++; last_rise[d] = cyc; end
            if (g_f[d] != 0) begin n_fall[d]++; last_fall[d] = cyc; end
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int t0, r0, f0;
        rst     = 1'b1;
        cnt_clr = 1'b0;
        for (int d = 0; d < 4; d++) begin
            din[d] = p_init[d];
            n_rise[d] = 0; n_fall[d] = 0; last_rise[d] = -1; last_fall[d] = -1;
        end
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();
        check("no_pulse_after_reset", n_rise[0] + n_fall[0] + n_rise[3] + n_fall[3], 0);

        // N=3, FILT=0 latency for rise and fall.
        t0 = cyc; din[1] = 4'd1;
        repeat (8) step();
        check("d1_rise_latency", last_rise[1], t0 + 4);
        t0 = cyc; din[1] = 4'd0;
        repeat (8) step();
        check("d1_fall_latency", last_fall[1], t0 + 4);

        // FILT=3: a 3-cycle pulse is rejected, a 4-cycle pulse passes.
        r0 = n_rise[2]; din[2] = 4'd1;
        repeat (3) step();
        din[2] = 4'd0;
        repeat (8) step();
        check("d2_glitch_rejected", n_rise[2], r0);
        t0 = cyc; din[2] = 4'd1;
        repeat (4) step();
        din[2] = 4'd0;
        repeat (10) step();
        check("d2_filter_latency", last_rise[2], t0 + 6);
        check("d2_single_rise", n_rise[2], r0 + 1);

        // Two channels changing in opposite directions on the same cycle.
        t0 = cyc; r0 = n_rise[3]; f0 = n_fall[3]; din[3] = 4'b0001;
        repeat (8) step();
        check("d3_rise_at", last_rise[3], t0 + 5);
        check("d3_fall_at", last_fall[3], t0 + 5);
        check("d3_pulse_widths", (n_rise[3] - r0) * 16 + (n_fall[3] - f0), 17);

        // Reset mid-filter, then the update restarts from scratch.
        din[2] = 4'd1;
        repeat (4) step();
        pulse_rst();
        t0 = cyc;
        repeat (10) step();
        check("d2_update_after_rst", last_rise[2], t0 + 6);

        // Saturation of the 2-bit counter.
        repeat (5) begin
            din[2] = 4'd1; repeat (5) step();
            din[2] = 4'd0; repeat (5) step();
        end
`ifdef SYNC_EVT_CNT_EN
        check("d2_evt_saturated", g_evt[2][0], 3);
`endif

        // Clear held across a rise: counter shows exactly one.
        cnt_clr = 1'b1; din[1] = 4'd1; r0 = n_rise[1];
        for (int k = 0; k < 20 && n_rise[1] == r0; k++) step();
        check("d1_rise_seen", n_rise[1] - r0, 1);
`ifdef SYNC_EVT_CNT_EN
        check("d1_evt_clr_and_count", g_evt[1][0], 1);
`endif
        step();
        cnt_clr = 1'b0;

        repeat (1500) begin
            for (int d = 0; d < 4; d++)
                for (int c = 0; c < p_w[d]; c++)
                    if ($urandom_range(3) == 0) din[d][c] = ~din[d][c];
            cnt_clr = ($urandom_range(40) == 0);
            if ($urandom_range(400) == 0) pulse_rst();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
